yolo_cls_filter: RTL

- Downstream consumer of the 3-way class comparator in the YOLO head post-processing path.
- Takes one per-grid-cell result per beat: winning class score and class index.
- Tracks the cell's grid (x, y) position, keeps cells whose score exceeds a programmable threshold, and buffers them in a small FWFT FIFO.
- Drains detections over a valid/ready stream and pulses frame completion.

---
 rtl/yolo_cls_filter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/yolo_cls_filter.sv
// Per-cell score threshold filter for the YOLO head: tags each comparator result with its
// grid (x, y), keeps cells above a frame-latched threshold and buffers them in a FWFT FIFO.
module yolo_cls_filter #(
    parameter int GRID_W     = 13,
    parameter int GRID_H     = 13,
    parameter int COORD_W    = 4,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [7:0]             thresh,
    input  logic                   in_valid,
    input  logic [7:0]             in_score,
    input  logic [1:0]             in_class,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [2*COORD_W+9:0]   out_data,
    output logic                   busy,
    output logic                   frame_done,
    output logic [7:0]             det_count,
    output logic                   overflow
);
    localparam int DW = 2*COORD_W + 10;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [COORD_W-1:0] X_LAST    = COORD_W'(GRID_W - 1);
    localparam logic [COORD_W-1:0] Y_LAST    = COORD_W'(GRID_H - 1);
    localparam logic [COORD_W-1:0] COORD_ONE = COORD_W'(1);
    localparam logic [AW:0]        PTR_ONE   = (AW+1)'(1);

    typedef enum logic [1:0] {IDLE, RUN, FLUSH, DONE} state_t;

    state_t             state, state_nxt;
    logic [7:0]         thresh_q;
    logic [COORD_W-1:0] x, y;
    logic [DW-1:0]      mem [FIFO_DEPTH];
    logic [AW:0]        wr_ptr, rd_ptr;
    logic               empty, full, pop, push, pass, beat, last_cell;

    assign beat      = (state == RUN) && in_valid;
    assign pass      = beat && (in_score > thresh_q);
    assign last_cell = (x == X_LAST) && (y == Y_LAST);

    // Pointers carry an extra wrap bit so full and empty are told apart by comparison alone.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = !empty && out_ready;
    // A full buffer still takes a push when its head leaves in the same cycle.
    assign push  = pass && (!full || pop);

    assign out_valid = !empty;
    assign out_data  = empty ? '0 : mem[rd_ptr[AW-1:0]];

    always_comb begin
        state_nxt  = state;
        busy       = 1'b0;
        frame_done = 1'b0;
        case (state)
            IDLE:  if (start) state_nxt = RUN;
            RUN: begin
                busy = 1'b1;
                if (beat && last_cell) state_nxt = FLUSH;
            end
            FLUSH: begin
                busy = 1'b1;
                if (empty) state_nxt = DONE;
            end
            DONE: begin
                frame_done = 1'b1;
                state_nxt  = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            thresh_q  <= '0;
            x         <= '0;
            y         <= '0;
            det_count <= '0;
            overflow  <= 1'b0;
        end else if (state == IDLE && start) begin
            thresh_q  <= thresh;
            x         <= '0;
            y         <= '0;
            det_count <= '0;
            overflow  <= 1'b0;
        end else begin
            if (beat) begin
                if (x == X_LAST) begin
                    x <= '0;
                    y <= (y == Y_LAST) ? '0 : y + COORD_ONE;
                end else begin
                    x <= x + COORD_ONE;
                end
            end
            if (push && det_count != 8'hFF) det_count <= det_count + 8'd1;
            if (pass && !push)              overflow  <= 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop)  rd_ptr <= rd_ptr + PTR_ONE;
        end
    end

    // NOTE: storage is not reset; the pointers alone define which entries are live.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr[AW-1:0]] <= {y, x, in_class, in_score};
    end

endmodule
